// File: rtl/vga_if.sv
// vga_if: pixel-strobe/mode controls in, sync/coordinate/colour outputs to the VGA DAC.
interface vga_if #(
    parameter int CNT_W   = 10,
    parameter int COLOR_W = 4
);
    logic                   pix_en;
    logic [1:0]             mode;
    logic [3*COLOR_W-1:0]   color_in;
    logic                   vga_hsync;
    logic                   vga_vsync;
    logic                   vga_valid;
    logic [CNT_W-1:0]       h_addr;
    logic [CNT_W-1:0]       v_addr;
    logic [COLOR_W-1:0]     vga_red;
    logic [COLOR_W-1:0]     vga_green;
    logic [COLOR_W-1:0]     vga_blue;
    logic                   frame_start;

    modport master (
        input  pix_en, mode, color_in,
        output vga_hsync, vga_vsync, vga_valid, h_addr, v_addr,
               vga_red, vga_green, vga_blue, frame_start
    );

    modport slave (
        output pix_en, mode, color_in,
        input  vga_hsync, vga_vsync, vga_valid, h_addr, v_addr,
               vga_red, vga_green, vga_blue, frame_start
    );
endinterface

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: pix_en-gated VGA timing with solid, colour-bar, checkerboard and bouncing-box patterns.
module vga_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int CNT_W    = 10,
    parameter int COLOR_W  = 4,
    parameter int CHK_LOG2 = 5,
    parameter int BOX_SIZE = 32
) (
    input  logic clk,
    input  logic rst_n,
    vga_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [CNT_W-1:0] H_MAX   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_MAX   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] BAR_MAX = CNT_W'(H_ACTIVE / 8 - 1);
    localparam logic [CNT_W-1:0] BX_MAX  = CNT_W'(H_ACTIVE - BOX_SIZE);
    localparam logic [CNT_W-1:0] BY_MAX  = CNT_W'(V_ACTIVE - BOX_SIZE);
    localparam logic [CNT_W-1:0] BOX     = CNT_W'(BOX_SIZE);
    localparam logic [3*COLOR_W-1:0] WHITE = '1;

    logic [CNT_W-1:0] h_cnt, v_cnt, bar_pix;
    logic [2:0]       bar_idx;
    logic [1:0]       mode_q, cur_mode;
    logic [CNT_W-1:0] bx, by, dx, dy, nbx, nby, bdx, bdy;
    logic             dir_x, dir_y, ndir_x, ndir_y;
    logic             first_px, valid, h_wrap, in_box, chk;
    logic [COLOR_W-1:0] ones;
    logic [3*COLOR_W-1:0] bar_rgb, rgb;

    always_comb begin
        first_px = h_cnt == '0 && v_cnt == '0;
        h_wrap   = h_cnt == H_MAX;
        valid    = h_cnt < H_ACT && v_cnt < V_ACT;
        cur_mode = first_px ? vga.mode : mode_q;
        ndir_x   = dir_x ? bx != BX_MAX : bx == '0;
        ndir_y   = dir_y ? by != BY_MAX : by == '0;
        nbx      = ndir_x ? bx + 1'b1 : bx - 1'b1;
        nby      = ndir_y ? by + 1'b1 : by - 1'b1;
        // The frame's first pixel must already see the position latched at this tick
        bdx      = first_px ? bx : dx;
        bdy      = first_px ? by : dy;
        in_box   = h_cnt >= bdx && h_cnt < bdx + BOX && v_cnt >= bdy && v_cnt < bdy + BOX;
        chk      = h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2];
        ones     = '1;
        bar_rgb  = {bar_idx[1] ? '0 : ones, bar_idx[2] ? '0 : ones, bar_idx[0] ? '0 : ones};
        rgb      = cur_mode == 2'd0 ? vga.color_in :
                   cur_mode == 2'd1 ? bar_rgb :
                   cur_mode == 2'd2 ? (chk ? WHITE : '0) :
                   (in_box ? WHITE : vga.color_in);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt           <= '0;
            v_cnt           <= '0;
            bar_pix         <= '0;
            bar_idx         <= '0;
            mode_q          <= '0;
            bx              <= '0;
            by              <= '0;
            dx              <= '0;
            dy              <= '0;
            dir_x           <= 1'b1;
            dir_y           <= 1'b1;
            vga.vga_hsync   <= ~SYNC_POL;
            vga.vga_vsync   <= ~SYNC_POL;
            vga.vga_valid   <= 1'b0;
            vga.h_addr      <= '0;
            vga.v_addr      <= '0;
            {vga.vga_red, vga.vga_green, vga.vga_blue} <= '0;
            vga.frame_start <= 1'b0;
        end else begin
            vga.frame_start <= vga.pix_en && first_px;
            if (vga.pix_en) begin
                h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
                if (h_wrap)
                    v_cnt <= v_cnt == V_MAX ? '0 : v_cnt + 1'b1;
                // Bar index tracks h_cnt incrementally, avoiding a divider
                if (h_wrap) begin
                    bar_pix <= '0;
                    bar_idx <= '0;
                end else if (bar_pix == BAR_MAX) begin
                    bar_pix <= '0;
                    bar_idx <= bar_idx + 3'd1;
                end else begin
                    bar_pix <= bar_pix + 1'b1;
                end
                if (first_px) begin
                    mode_q <= vga.mode;
                    dx     <= bx;
                    dy     <= by;
                    bx     <= nbx;
                    by     <= nby;
                    dir_x  <= ndir_x;
                    dir_y  <= ndir_y;
                end
                vga.vga_hsync <= (h_cnt >= HS_BEG && h_cnt < HS_END) ? SYNC_POL : ~SYNC_POL;
                vga.vga_vsync <= (v_cnt >= VS_BEG && v_cnt < VS_END) ? SYNC_POL : ~SYNC_POL;
                vga.vga_valid <= valid;
                vga.h_addr    <= valid ? h_cnt : '0;
                vga.v_addr    <= valid ? v_cnt : '0;
                {vga.vga_red, vga.vga_green, vga.vga_blue} <= valid ? rgb : '0;
            end
        end
    end
endmodule
